// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Consumer end of the PLL lock/reset handshake. The block holds the PLL in
//   reset, waits for lock, and requires lock to stay high for a run of
//   consecutive cycles before it releases the system reset. If lock is lost
//   in RUN, or never arrives within the timeout, the PLL is reset again.
//   Runs on the free-running board reference clock, never on the PLL output.
//
// Ports
//   clk          board reference clock, rising edge
//   rst          synchronous active-high reset
//   lock         PLL lock, asynchronous to clk
//   clr_cnt      synchronous clear of both event counters (wins over increment)
//   pll_rst      reset to the PLL, high only in RESET_PLL
//   sys_rst      downstream reset, low only in RUN
//   locked       high only in RUN
//   state        0=RESET_PLL 1=WAIT_LOCK 2=FILTER 3=RUN
//   loss_cnt     saturating count of RUN->RESET_PLL transitions
//   timeout_cnt  saturating count of WAIT_LOCK timeouts
module pll_lock_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock,
  input  logic             clr_cnt,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             locked,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    FILTER    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // The phase counter only has to reach the largest terminal count minus one.
  localparam int PH_A   = (RST_HOLD > LOCK_FILTER) ? RST_HOLD : LOCK_FILTER;
  localparam int PH_MAX = (PH_A > LOCK_TIMEOUT) ? PH_A : LOCK_TIMEOUT;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] HOLD_END    = PH_W'(RST_HOLD - 1);
  localparam logic [PH_W-1:0] FILTER_END  = PH_W'(LOCK_FILTER - 1);
  localparam logic [PH_W-1:0] TIMEOUT_END = PH_W'(LOCK_TIMEOUT - 1);

  state_t                 state_q;
  state_t                 state_n;
  logic [PH_W-1:0]        phase_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   loss_inc;
  logic                   timeout_inc;

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign state  = state_q;

  // Next-state decision; the counters and outputs are registered from it below.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_n     = state_q;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;
    unique case (state_q)
      RESET_PLL: begin
        // lock_s is deliberately ignored while the PLL is held in reset.
        if (phase_q == HOLD_END) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = FILTER;
        end else if (phase_q == TIMEOUT_END) begin
          state_n     = RESET_PLL;
          timeout_inc = 1'b1;
        end
      end
      FILTER: begin
        // Any drop sends us back to WAIT_LOCK, which restarts the timeout.
        if (!lock_s)                   state_n = WAIT_LOCK;
        else if (phase_q == FILTER_END) state_n = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_n  = RESET_PLL;
          loss_inc = 1'b1;
        end
      end
      default: state_n = RESET_PLL;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      phase_q     <= '0;
      sync_q      <= '0;
      loss_cnt    <= '0;
      timeout_cnt <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      locked      <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], lock};
      state_q <= state_n;

      // Counts cycles spent in the current state; wraps harmlessly in RUN.
      if (state_n != state_q) phase_q <= '0;
      else                    phase_q <= phase_q + PH_W'(1);

      if (clr_cnt)                          loss_cnt <= '0;
      else if (loss_inc && loss_cnt != '1)  loss_cnt <= loss_cnt + CNT_W'(1);

      if (clr_cnt)                                timeout_cnt <= '0;
      else if (timeout_inc && timeout_cnt != '1)  timeout_cnt <= timeout_cnt + CNT_W'(1);

      // Outputs are a pure function of the state being entered, so they are
      // glitch-free and have no path from lock.
      pll_rst <= (state_n == RESET_PLL);
      sys_rst <= (state_n != RUN);
      locked  <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

  localparam int SYNC_STAGES  = 2;
  localparam int RST_HOLD     = 4;
  localparam int LOCK_FILTER  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // State codes as defined at the port.
  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_FILT = 2;
  localparam int M_RUN  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lock = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             pll_rst;
  logic             sys_rst;
  logic             locked;
  logic [1:0]       state;
  logic [CNT_W-1:0] loss_cnt;
  logic [CNT_W-1:0] timeout_cnt;

  int n_checks = 0;
  int n_err    = 0;

  pll_lock_sequencer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_HOLD    (RST_HOLD),
    .LOCK_FILTER (LOCK_FILTER),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock       (lock),
    .clr_cnt    (clr_cnt),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .locked     (locked),
    .state      (state),
    .loss_cnt   (loss_cnt),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: mode plus the edge on which it was entered. The delayed
  // lock view is a queue of past samples; elapsed time is plain subtraction.
  // ---------------------------------------------------------------------------
  int   cyc       = 0;
  int   m_mode    = M_RST;
  int   m_entered = 0;
  int   m_loss    = 0;
  int   m_to      = 0;
  bit   m_valid   = 0;
  bit   lock_hist[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_mode    = M_RST;
        m_entered = cyc;
        m_loss    = 0;
        m_to      = 0;
        lock_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) lock_hist.push_back(1'b0);
      end else begin
        bit ls;
        int age;
        int nxt;
        bit inc_loss;
        bit inc_to;
        ls = lock_hist.pop_front();
        lock_hist.push_back(lock);
        age      = cyc - m_entered;   // 1 on the first edge after entry
        nxt      = m_mode;
        inc_loss = 0;
        inc_to   = 0;
        case (m_mode)
          M_RST:  if (age == RST_HOLD) nxt = M_WAIT;
          M_WAIT: if (ls) nxt = M_FILT;
                  else if (age == LOCK_TIMEOUT) begin nxt = M_RST; inc_to = 1; end
          M_FILT: if (!ls) nxt = M_WAIT;
                  else if (age == LOCK_FILTER) nxt = M_RUN;
          default: if (!ls) begin nxt = M_RST; inc_loss = 1; end
        endcase
        if (clr_cnt) begin
          m_loss = 0;
          m_to   = 0;
        end else begin
          if (inc_loss && m_loss < CNT_MAX) m_loss++;
          if (inc_to && m_to < CNT_MAX)     m_to++;
        end
        if (nxt != m_mode) begin
          m_mode    = nxt;
          m_entered = cyc;
        end
      end
      m_valid = 1;
    end
  end

  // Single compare process: every cycle once the model has seen reset.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("state",       32'(state),       32'(m_mode));
        check("pll_rst",     32'(pll_rst),     32'(m_mode == M_RST));
        check("sys_rst",     32'(sys_rst),     32'(m_mode != M_RUN));
        check("locked",      32'(locked),      32'(m_mode == M_RUN));
        check("loss_cnt",    32'(loss_cnt),    32'(m_loss));
        check("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
      end
    end
  end

  // Drop lock for one sampled cycle, then wait until RUN is re-entered.
  task automatic drop_and_relock();
    lock = 1'b0;
    wait_n(1);
    lock = 1'b1;
    wait_n(16);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios with hand-computed literals, then random stimulus.
  // Edge numbering: edge 0 is the last edge that samples rst=1.
  // ---------------------------------------------------------------------------
  initial begin
    // Clean lock.
    wait_n(3);
    check("rst_state",   32'(state),       0);
    check("rst_pll_rst", 32'(pll_rst),     1);
    check("rst_sys_rst", 32'(sys_rst),     1);
    check("rst_locked",  32'(locked),      0);
    check("rst_loss",    32'(loss_cnt),    0);
    check("rst_to",      32'(timeout_cnt), 0);
    rst = 1'b0;
    wait_n(3);
    check("s1_pll_rst_e3", 32'(pll_rst), 1);
    wait_n(1);
    check("s1_pll_rst_e4", 32'(pll_rst), 0);
    check("s1_state_e4",   32'(state),   1);
    wait_n(5);
    lock = 1'b1;                          // first sampled at edge 10
    wait_n(10);
    check("s1_locked_e19", 32'(locked), 0);
    check("s1_state_e19",  32'(state),  2);
    wait_n(1);
    check("s1_locked_e20", 32'(locked),  1);
    check("s1_sysrst_e20", 32'(sys_rst), 0);
    check("s1_state_e20",  32'(state),   3);

    // Lock loss in RUN (lock low sampled at edge j).
    lock = 1'b0;
    wait_n(1);
    lock = 1'b1;
    wait_n(1);
    check("s4_state_j1", 32'(state), 3);
    wait_n(1);
    check("s4_state_j2",   32'(state),    0);
    check("s4_pll_rst_j2", 32'(pll_rst),  1);
    check("s4_sys_rst_j2", 32'(sys_rst),  1);
    check("s4_locked_j2",  32'(locked),   0);
    check("s4_loss_j2",    32'(loss_cnt), 1);
    wait_n(12);
    check("s4_locked_j14", 32'(locked), 0);
    wait_n(1);
    check("s4_locked_j15", 32'(locked), 1);

    // Clear on the same edge as a loss increment.
    lock = 1'b0;
    wait_n(1);
    lock = 1'b1;
    wait_n(1);
    clr_cnt = 1'b1;                       // sampled at edge j+2
    wait_n(1);
    clr_cnt = 1'b0;
    check("s5_loss",  32'(loss_cnt), 0);
    check("s5_state", 32'(state),    0);
    wait_n(13);
    check("s5_relock", 32'(locked), 1);

    // Reset in RUN with three recorded losses.
    drop_and_relock();
    drop_and_relock();
    drop_and_relock();
    check("s6_loss_pre",   32'(loss_cnt), 3);
    check("s6_locked_pre", 32'(locked),   1);
    rst  = 1'b1;
    lock = 1'b0;
    wait_n(1);
    check("s6_state",   32'(state),    0);
    check("s6_pll_rst", 32'(pll_rst),  1);
    check("s6_locked",  32'(locked),   0);
    check("s6_loss",    32'(loss_cnt), 0);

    // Glitchy lock: high 5 sampled cycles from edge k=10, low 1, then high.
    rst = 1'b0;
    wait_n(9);
    lock = 1'b1;
    wait_n(5);
    lock = 1'b0;
    wait_n(1);
    lock = 1'b1;                          // re-sampled high at k+6
    wait_n(1);
    check("s2_state_k6", 32'(state), 2);
    wait_n(1);
    check("s2_state_k7", 32'(state), 1);
    wait_n(8);
    check("s2_locked_k15", 32'(locked), 0);
    wait_n(1);
    check("s2_locked_k16", 32'(locked),   1);
    check("s2_loss",       32'(loss_cnt), 0);

    // Timeout with lock held low: one timeout every 36 edges.
    rst  = 1'b1;
    lock = 1'b0;
    wait_n(1);
    rst = 1'b0;
    wait_n(35);
    check("s3_to_e35",      32'(timeout_cnt), 0);
    check("s3_pll_rst_e35", 32'(pll_rst),     0);
    wait_n(1);
    check("s3_to_e36",      32'(timeout_cnt), 1);
    check("s3_pll_rst_e36", 32'(pll_rst),     1);
    wait_n(3);
    check("s3_pll_rst_e39", 32'(pll_rst), 1);
    wait_n(1);
    check("s3_pll_rst_e40", 32'(pll_rst), 0);
    wait_n(36 * 255 - 40);
    check("s3_to_255", 32'(timeout_cnt), 255);
    wait_n(36 * 46);
    check("s3_to_sat", 32'(timeout_cnt), 255);

    // Random lock waveform with occasional counter clears and resets.
    for (int r = 0; r < 160; r++) begin
      int len;
      lock = ~lock;
      len  = lock ? $urandom_range(1, 30) : $urandom_range(1, 45);
      for (int c = 0; c < len; c++) begin
        wait_n(1);
        clr_cnt = ($urandom_range(0, 29) == 0);
        rst     = ($urandom_range(0, 399) == 0);
      end
    end
    clr_cnt = 1'b0;
    rst     = 1'b0;
    wait_n(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
